// File: rtl/market_packet_transmitter.sv
// ----------------------------------------------------------------------------
// market_packet_transmitter
//
// Serialises one market-data update into an 18-byte big-endian wire frame,
// one byte per accepted cycle on the tx_* handshake. One update can be held
// pending while a frame is on the wire, so consecutive frames can go out
// back-to-back (or separated by INTER_PKT_GAP idle cycles).
//
// Frame layout (byte index: content), every field MSB first:
//   0      SYNC_BYTE
//   1-4    ticker[31:0]
//   5-8    timestamp[31:0]
//   9-11   ask[23:0]
//   12-14  bid[23:0]
//   15     position[15:8]
//   16     XOR of bytes 1..15
//   17     position[7:0]
//
// Ports
//   clk           in   1      clock
//   rst           in   1      synchronous, active-high reset
//   in_valid      in   1      update fields valid
//   in_ready      out  1      pending buffer empty (registered, no path from tx_ready)
//   in_ticker     in   32     4 ASCII chars, MSB = first char
//   in_timestamp  in   32     unsigned timestamp
//   in_ask_cents  in   24     unsigned ask price, cents
//   in_bid_cents  in   24     unsigned bid price, cents
//   in_position   in   16     two's complement position, shares
//   tx_byte       out  8      current wire byte (0 when tx_valid is low)
//   tx_valid      out  1      tx_byte valid
//   tx_ready      in   1      sink takes byte when tx_valid && tx_ready
//   tx_busy       out  1      FSM not idle
//   tx_done       out  1      pulse in the cycle the last byte (17) is taken
//   pkt_count     out  CNT_W  frames completed, wraps
// ----------------------------------------------------------------------------
module market_packet_transmitter #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         INTER_PKT_GAP = 0,
    parameter int         CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ticker,
    input  logic [31:0]      in_timestamp,
    input  logic [23:0]      in_ask_cents,
    input  logic [23:0]      in_bid_cents,
    input  logic [15:0]      in_position,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [4:0]  LAST_IDX = 5'd17;
    localparam logic [15:0] GAP_LOAD = 16'(INTER_PKT_GAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, next_state;

    // Pending update buffer
    logic        pend_valid;
    logic [31:0] pend_ticker;
    logic [31:0] pend_timestamp;
    logic [23:0] pend_ask;
    logic [23:0] pend_bid;
    logic [15:0] pend_position;

    // Active frame: shifted left one byte per take, so the wire byte is always
    // the top byte and naturally holds steady while the sink stalls.
    logic [143:0] frame_q;
    logic [143:0] frame_d;
    logic [119:0] payload;
    logic [7:0]   checksum;
    logic [4:0]   idx;
    logic [15:0]  gap_cnt;

    logic accept;
    logic load;
    logic take;
    logic last_take;

    assign in_ready = !pend_valid;
    assign accept   = in_valid && !pend_valid;

    // Bytes 1..15 of the frame, covered by the checksum.
    assign payload = {pend_ticker, pend_timestamp, pend_ask, pend_bid, pend_position[15:8]};

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < 15; i++) begin
            checksum = checksum ^ payload[i*8 +: 8];
        end
        frame_d = {SYNC_BYTE, payload, checksum, pend_position[7:0]};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        next_state = state;
        load       = 1'b0;
        take       = 1'b0;
        last_take  = 1'b0;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        tx_done    = 1'b0;
        tx_busy    = (state != IDLE);

        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load       = 1'b1;
                    next_state = SEND;
                end
            end

            SEND: begin
                tx_valid = 1'b1;
                tx_byte  = frame_q[143:136];
                if (tx_ready) begin
                    take = 1'b1;
                    if (idx == LAST_IDX) begin
                        last_take = 1'b1;
                        tx_done   = 1'b1;
                        if (INTER_PKT_GAP > 0) begin
                            next_state = GAP;
                        end else if (pend_valid) begin
                            // Reload in place: next frame's sync byte follows
                            // the previous frame's last byte with no bubble.
                            load = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_cnt == 16'd1) begin
                    if (pend_valid) begin
                        load       = 1'b1;
                        next_state = SEND;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            idx        <= 5'd0;
            gap_cnt    <= 16'd0;
            pkt_count  <= '0;
        end else begin
            // accept and load are mutually exclusive: load needs pend_valid,
            // accept needs it clear.
            if (accept) begin
                pend_valid <= 1'b1;
            end else if (load) begin
                pend_valid <= 1'b0;
            end

            if (load) begin
                idx <= 5'd0;
            end else if (take && !last_take) begin
                idx <= idx + 5'd1;
            end

            if (last_take) begin
                pkt_count <= pkt_count + CNT_W'(1);
                gap_cnt   <= GAP_LOAD;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

    // Datapath registers
    // NOTE: payload storage carries no reset; it is only observed once the
    // reset-cleared pend_valid / state qualify it, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_ticker    <= in_ticker;
            pend_timestamp <= in_timestamp;
            pend_ask       <= in_ask_cents;
            pend_bid       <= in_bid_cents;
            pend_position  <= in_position;
        end

        if (load) begin
            frame_q <= frame_d;
        end else if (take) begin
            frame_q <= {frame_q[135:0], 8'h00};
        end
    end

endmodule

// File: tb/tb_market_packet_transmitter.sv
// ----------------------------------------------------------------------------
// tb_market_packet_transmitter
//
// Two instances: dut_a (INTER_PKT_GAP = 0) and dut_b (INTER_PKT_GAP = 3).
// Inputs are driven just after the falling edge; outputs are sampled 1 ns
// later, half a period away from the rising edge. A byte-level reference
// model builds expected frames from the update fields, and a receiver-style
// decoder reassembles fields from the captured wire bytes.
// ----------------------------------------------------------------------------
module tb_market_packet_transmitter;

    typedef struct packed {
        logic [31:0] ticker;
        logic [31:0] ts;
        logic [23:0] ask;
        logic [23:0] bid;
        logic [15:0] pos;
    } upd_t;

    logic        clk;
    logic        rst;
    logic        sel_gap;
    logic        drv_valid;
    logic        drv_ready;
    logic [31:0] f_ticker;
    logic [31:0] f_ts;
    logic [23:0] f_ask;
    logic [23:0] f_bid;
    logic [15:0] f_pos;

    logic        a_in_valid, b_in_valid;
    logic        a_in_ready, b_in_ready;
    logic [7:0]  a_tx_byte, b_tx_byte;
    logic        a_tx_valid, b_tx_valid;
    logic        a_tx_busy, b_tx_busy;
    logic        a_tx_done, b_tx_done;
    logic [15:0] a_pkt_count, b_pkt_count;

    logic        m_in_ready;
    logic [7:0]  m_tx_byte;
    logic        m_tx_valid;
    logic        m_tx_busy;
    logic        m_tx_done;
    logic [15:0] m_pkt_count;

    assign a_in_valid  = drv_valid & ~sel_gap;
    assign b_in_valid  = drv_valid & sel_gap;
    assign m_in_ready  = sel_gap ? b_in_ready  : a_in_ready;
    assign m_tx_byte   = sel_gap ? b_tx_byte   : a_tx_byte;
    assign m_tx_valid  = sel_gap ? b_tx_valid  : a_tx_valid;
    assign m_tx_busy   = sel_gap ? b_tx_busy   : a_tx_busy;
    assign m_tx_done   = sel_gap ? b_tx_done   : a_tx_done;
    assign m_pkt_count = sel_gap ? b_pkt_count : a_pkt_count;

    market_packet_transmitter #(.SYNC_BYTE(8'hA5), .INTER_PKT_GAP(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ticker(f_ticker), .in_timestamp(f_ts),
        .in_ask_cents(f_ask), .in_bid_cents(f_bid), .in_position(f_pos),
        .tx_byte(a_tx_byte), .tx_valid(a_tx_valid), .tx_ready(drv_ready),
        .tx_busy(a_tx_busy), .tx_done(a_tx_done), .pkt_count(a_pkt_count)
    );

    market_packet_transmitter #(.SYNC_BYTE(8'hA5), .INTER_PKT_GAP(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ticker(f_ticker), .in_timestamp(f_ts),
        .in_ask_cents(f_ask), .in_bid_cents(f_bid), .in_position(f_pos),
        .tx_byte(b_tx_byte), .tx_valid(b_tx_valid), .tx_ready(drv_ready),
        .tx_busy(b_tx_busy), .tx_done(b_tx_done), .pkt_count(b_pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    upd_t       upd_q[$];
    upd_t       sent_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         vtrace[$];
    int         acc_cyc[$];
    int         done_cnt;

    logic [7:0] t1_bytes [18] = '{8'hA5, 8'h41, 8'h41, 8'h50, 8'h4C, 8'h00, 8'h00, 8'h03, 8'hE8,
                                  8'h00, 8'h49, 8'hED, 8'h00, 8'h49, 8'hE8, 8'hFF, 8'h0D, 8'hFB};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic upd_t rand_upd();
        upd_t u;
        u.ticker = $urandom;
        u.ts     = $urandom;
        u.ask    = 24'($urandom);
        u.bid    = 24'($urandom);
        u.pos    = 16'($urandom);
        return u;
    endfunction

    task automatic set_fields(input upd_t u);
        f_ticker = u.ticker;
        f_ts     = u.ts;
        f_ask    = u.ask;
        f_bid    = u.bid;
        f_pos    = u.pos;
    endtask

    // Reference frame: fields sliced out MSB-first by shifting, checksum by XOR.
    function automatic void push_frame(input upd_t u);
        logic [7:0] b [18];
        b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            b[1+i] = 8'(u.ticker >> (24 - 8*i));
            b[5+i] = 8'(u.ts >> (24 - 8*i));
        end
        for (int i = 0; i < 3; i++) begin
            b[9+i]  = 8'(u.ask >> (16 - 8*i));
            b[12+i] = 8'(u.bid >> (16 - 8*i));
        end
        b[15] = 8'(u.pos >> 8);
        b[17] = 8'(u.pos);
        b[16] = 8'h00;
        for (int i = 1; i <= 15; i++) b[16] = b[16] ^ b[i];
        for (int i = 0; i < 18; i++) exp_q.push_back(b[i]);
    endfunction

    // Offers every update in upd_q in order, records wire bytes and per-cycle
    // tx_valid, and checks the per-cycle handshake rules along the way.
    task automatic run_stream(input bit rand_ready, input bit rand_valid, input int max_cycles);
        bit fin;
        bit exp_done;
        fin = 1'b0;
        rx_q.delete(); exp_q.delete(); vtrace.delete(); sent_q.delete(); acc_cyc.delete();
        done_cnt = 0;
        for (int c = 0; c < max_cycles && !fin; c++) begin
            @(negedge clk);
            drv_valid = (upd_q.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
            if (drv_valid) set_fields(upd_q[0]);
            else set_fields(rand_upd());
            drv_ready = !rand_ready || ($urandom_range(0, 3) != 0);
            #1;
            vtrace.push_back(m_tx_valid);
            exp_done = m_tx_valid && drv_ready && ((rx_q.size() % 18) == 17);
            check("stream_tx_done", m_tx_done, exp_done);
            if (!m_tx_valid) check("stream_idle_byte_zero", m_tx_byte, 8'h00);
            if ((rx_q.size() % 18) != 0) check("stream_valid_mid_frame", m_tx_valid, 1'b1);
            if (m_tx_done) done_cnt++;
            if (m_tx_valid && drv_ready) rx_q.push_back(m_tx_byte);
            if (drv_valid && m_in_ready) begin
                sent_q.push_back(upd_q.pop_front());
                push_frame(sent_q[sent_q.size()-1]);
                acc_cyc.push_back(c);
            end
            fin = (upd_q.size() == 0) && (rx_q.size() == sent_q.size() * 18) && !m_tx_busy;
        end
        check("stream_finished", fin, 1'b1);
        drv_valid = 1'b0;
        drv_ready = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_byte"}, rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        upd_t       u1, ua, ub, uc, uk;
        upd_t       q[$];
        int         b, stall, vcyc, i, r1, z, r2, taken, first, last, ones, base;
        bit         reached;
        logic [7:0] x;

        sel_gap   = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        set_fields('0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        rst = 1'b0;
        #1;
        check("rst_tx_valid", a_tx_valid, 1'b0);
        check("rst_tx_byte", a_tx_byte, 8'h00);
        check("rst_tx_busy", a_tx_busy, 1'b0);
        check("rst_tx_done", a_tx_done, 1'b0);
        check("rst_pkt_count", a_pkt_count, 16'd0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_b_pkt_count", b_pkt_count, 16'd0);
        check("rst_b_in_ready", b_in_ready, 1'b1);

        // ---------------- T1: single AAPL frame ----------------
        u1 = '{ticker: 32'h4141504C, ts: 32'd1000, ask: 24'd18925, bid: 24'd18920, pos: 16'hFFFB};
        @(negedge clk);
        set_fields(u1); drv_valid = 1'b1;
        #1;
        check("t1_in_ready_before", m_in_ready, 1'b1);
        @(negedge clk);
        drv_valid = 1'b0; set_fields(rand_upd());
        #1;
        check("t1_in_ready_pending", m_in_ready, 1'b0);
        check("t1_valid_before_load", m_tx_valid, 1'b0);
        check("t1_busy_before_load", m_tx_busy, 1'b0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            set_fields(rand_upd());
            #1;
            check("t1_tx_valid", m_tx_valid, 1'b1);
            check("t1_tx_byte", m_tx_byte, t1_bytes[c]);
            check("t1_tx_done", m_tx_done, c == 17);
        end
        @(negedge clk);
        #1;
        check("t1_valid_after", m_tx_valid, 1'b0);
        check("t1_byte_after", m_tx_byte, 8'h00);
        check("t1_busy_after", m_tx_busy, 1'b0);
        check("t1_pkt_count", m_pkt_count, 16'd1);
        check("t1_in_ready_after", m_in_ready, 1'b1);

        // ---------------- T2: backpressure at index 8 ----------------
        @(negedge clk);
        set_fields(u1); drv_valid = 1'b1;
        #1;
        @(negedge clk);
        drv_valid = 1'b0;
        #1;
        b = 0; stall = 0; vcyc = 0;
        while (b < 18 && vcyc < 40) begin
            @(negedge clk);
            drv_ready = !(b == 8 && stall < 3);
            if (!drv_ready) stall++;
            #1;
            check("t2_tx_valid", m_tx_valid, 1'b1);
            check("t2_tx_byte", m_tx_byte, t1_bytes[b]);
            check("t2_tx_done", m_tx_done, (b == 17) && drv_ready);
            vcyc++;
            if (drv_ready) b++;
        end
        drv_ready = 1'b1;
        check("t2_frame_cycles", vcyc, 21);
        @(negedge clk);
        #1;
        check("t2_valid_after", m_tx_valid, 1'b0);
        check("t2_pkt_count", m_pkt_count, 16'd2);

        // ---------------- T3: back-to-back, no gap ----------------
        upd_q.delete();
        upd_q.push_back(rand_upd());
        upd_q.push_back(rand_upd());
        run_stream(1'b0, 1'b0, 200);
        compare_stream("t3");
        check("t3_accept_spacing", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1, 2);
        first = -1; last = -1; ones = 0;
        for (int k = 0; k < vtrace.size(); k++) begin
            if (vtrace[k]) begin
                if (first < 0) first = k;
                last = k;
                ones++;
            end
        end
        check("t3_valid_cycles", ones, 36);
        check("t3_contiguous", last - first + 1, 36);
        check("t3_done_pulses", done_cnt, 2);
        check("t3_pkt_count", m_pkt_count, 16'd4);

        // ---------------- T4: INTER_PKT_GAP = 3 ----------------
        sel_gap = 1'b1;
        upd_q.delete();
        upd_q.push_back(rand_upd());
        upd_q.push_back(rand_upd());
        run_stream(1'b0, 1'b0, 200);
        compare_stream("t4");
        i = 0; r1 = 0; z = 0; r2 = 0;
        while (i < vtrace.size() && !vtrace[i]) i++;
        while (i < vtrace.size() && vtrace[i]) begin r1++; i++; end
        while (i < vtrace.size() && !vtrace[i]) begin z++; i++; end
        while (i < vtrace.size() && vtrace[i]) begin r2++; i++; end
        check("t4_first_run", r1, 18);
        check("t4_gap_cycles", z, 3);
        check("t4_second_run", r2, 18);
        check("t4_pkt_count", m_pkt_count, 16'd2);
        sel_gap = 1'b0;

        // ---------------- T5: reset mid-frame with pending update ----------------
        ua = rand_upd();
        ub = rand_upd();
        q.delete();
        q.push_back(ua);
        q.push_back(ub);
        taken = 0; reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            @(negedge clk);
            drv_ready = 1'b1;
            drv_valid = (q.size() > 0);
            if (drv_valid) set_fields(q[0]);
            #1;
            if (drv_valid && m_in_ready) void'(q.pop_front());
            if (m_tx_valid) begin
                if (taken == 6) reached = 1'b1;
                taken++;
            end
        end
        check("t5_reached_idx", reached, 1'b1);
        check("t5_pending_held", m_in_ready, 1'b0);
        @(negedge clk);
        drv_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_valid_after_rst", m_tx_valid, 1'b0);
        check("t5_in_ready_after_rst", m_in_ready, 1'b1);
        check("t5_pkt_count_after_rst", m_pkt_count, 16'd0);
        check("t5_busy_after_rst", m_tx_busy, 1'b0);
        check("t5_byte_after_rst", m_tx_byte, 8'h00);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t5_pending_dropped", m_tx_valid, 1'b0);
        end
        uc = rand_upd();
        upd_q.delete();
        upd_q.push_back(uc);
        run_stream(1'b0, 1'b0, 100);
        compare_stream("t5");
        x = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        check("t5_first_sync", x, 8'hA5);
        check("t5_pkt_count", m_pkt_count, 16'd1);

        // ---------------- T6: 100 random updates through a receiver ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        upd_q.delete();
        for (int k = 0; k < 100; k++) begin
            uk = rand_upd();
            case (k)
                0: begin uk.pos = 16'h8000; uk.ask = 24'hFFFFFF; end
                1: begin uk.pos = 16'h7FFF; uk.bid = 24'hFFFFFF; end
                2: uk = '0;
                3: uk = '1;
                default: ;
            endcase
            upd_q.push_back(uk);
        end
        run_stream(1'b1, 1'b1, 8000);
        check("t6_sent", sent_q.size(), 100);
        check("t6_rx_len", rx_q.size(), 1800);
        for (int k = 0; k < sent_q.size() && (k * 18 + 17) < rx_q.size(); k++) begin
            base = k * 18;
            x = 8'h00;
            for (int j = 1; j <= 15; j++) x = x ^ rx_q[base + j];
            check("t6_sync", rx_q[base], 8'hA5);
            check("t6_checksum", rx_q[base + 16], x);
            check("t6_ticker", {rx_q[base+1], rx_q[base+2], rx_q[base+3], rx_q[base+4]}, sent_q[k].ticker);
            check("t6_timestamp", {rx_q[base+5], rx_q[base+6], rx_q[base+7], rx_q[base+8]}, sent_q[k].ts);
            check("t6_ask", {rx_q[base+9], rx_q[base+10], rx_q[base+11]}, sent_q[k].ask);
            check("t6_bid", {rx_q[base+12], rx_q[base+13], rx_q[base+14]}, sent_q[k].bid);
            check("t6_position", {rx_q[base+15], rx_q[base+17]}, sent_q[k].pos);
        end
        check("t6_done_pulses", done_cnt, 100);
        check("t6_pkt_count", m_pkt_count, 16'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
